// File: rtl/sobel_window.sv
// sobel_window: streaming 3x3 Sobel gradient over a raster-order frame.
// Two line buffers supply the two rows above the incoming pixel. A 3x3
// register window shifts on every accepted pixel. Each valid window is
// registered once more, so the |Gx|/|Gy| results appear one cycle after
// the window-completing pixel has been accepted.
module sobel_window #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  output logic [7:0] gx,
  output logic [7:0] gy,
  output logic       out_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Raster position of the pixel currently presented on pixel_in.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_col, last_row;

  // Line buffers: lb_old holds row-2, lb_mid holds row-1, indexed by column.
  logic [7:0] lb_old [IMG_W];
  logic [7:0] lb_mid [IMG_W];

  // Incoming window column: [0]=oldest row, [2]=current pixel.
  logic [7:0] col_new [3];

  // Window registers win_q[i][j]: i=row (0 oldest), j=column (0 leftmost).
  logic [7:0] win_q [3][3];

  // Window-complete flags, one cycle behind the accepting edge.
  logic win_valid_q, win_last_q;

  // Gradient arithmetic, wide enough for the full +/-1020 range.
  logic [11:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [11:0] gx_raw, gy_raw;

  logic [7:0] gx_q, gy_q;
  logic       out_valid_q, frame_done_q;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

  // Absolute value clamped to the 8-bit output range.
  function automatic logic [7:0] sat_abs(input logic signed [11:0] v);
    logic [11:0] mag;
    mag = v[11] ? 12'(-v) : 12'(v);
    return (mag > 12'd255) ? 8'hFF : mag[7:0];
  endfunction

  // Next raster position; wraps the column at row end and both at frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Raster counters; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Assemble the new window column from both line buffers and the input.
  always_comb begin
    col_new[0] = lb_old[col_q];
    col_new[1] = lb_mid[col_q];
    col_new[2] = pixel_in;
  end

  // Line buffers age by one row at this column. Their contents are never
  // reset: stale data only reaches windows that are masked off as border.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb_old[col_q] <= lb_mid[col_q];
      lb_mid[col_q] <= pixel_in;
    end
  end

  // Shift the 3x3 window left by one column on each accepted pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (pixel_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
        win_q[i][2] <= col_new[i];
      end
    end
  end

  // Flag windows whose three columns all belong to the current three rows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      win_valid_q <= pixel_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
      win_last_q  <= pixel_valid && last_row && last_col;
    end
  end

  // Sobel kernels as positive and negative weighted column/row sums.
  always_comb begin
    gx_pos = {4'd0, win_q[0][2]} + {3'd0, win_q[1][2], 1'b0} + {4'd0, win_q[2][2]};
    gx_neg = {4'd0, win_q[0][0]} + {3'd0, win_q[1][0], 1'b0} + {4'd0, win_q[2][0]};
    gy_pos = {4'd0, win_q[2][0]} + {3'd0, win_q[2][1], 1'b0} + {4'd0, win_q[2][2]};
    gy_neg = {4'd0, win_q[0][0]} + {3'd0, win_q[0][1], 1'b0} + {4'd0, win_q[0][2]};
    gx_raw = signed'(gx_pos - gx_neg);
    gy_raw = signed'(gy_pos - gy_neg);
  end

  // Register results; gx/gy hold their value between valid windows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gx_q         <= '0;
      gy_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= win_valid_q;
      frame_done_q <= win_last_q;
      if (win_valid_q) begin
        gx_q <= sat_abs(gx_raw);
        gy_q <= sat_abs(gy_raw);
      end
    end
  end

  assign gx         = gx_q;
  assign gy         = gy_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter: IMG_W, default 16, pixels per row (≥3).
REQ-002 Parameter: IMG_H, default 16, rows per frame (≥3).
REQ-003 Port: clk  input  1  single system clock; all state on its rising edge.
REQ-004 Port: n_rst  input  1  asynchronous reset, active-low.
REQ-005 Port: pixel_in  input  8  unsigned grayscale pixel, raster order (row 0 col 0 first).
REQ-006 Port: pixel_valid  input  1  pixel_in is consumed on every rising edge where this is high; no backpressure.
REQ-007 Port: gx  output  8  saturated |Gx| for the current window; feeds the gradient-magnitude stage.
REQ-008 Port: gy  output  8  saturated |Gy| for the current window.
REQ-009 Port: out_valid  output  1  high for exactly one cycle per produced window.
REQ-010 Port: frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-011 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on accepted pixels.
REQ-012 On an accepted pixel, col SHALL increment and, at IMG_W-1, wrap to 0 and increment row; at (IMG_H-1, IMG_W-1), both SHALL wrap to 0 (next pixel starts a new frame).
REQ-013 The block SHALL hold two line buffers of IMG_W×8 bits (previous two rows) plus a 3×3 register window, shifted only on accepted pixels.
REQ-014 Window notation p[i][j]: i=0 oldest row, i=2 current row; j=0 leftmost column, j=2 the accepted pixel's column.
REQ-015 A window SHALL be valid when the accepted pixel has row≥2 and col≥2; its center is pixel (row-1, col-1); border pixels produce no output.
REQ-016 Gx SHALL be (p[0][2]+2·p[1][2]+p[2][2]) − (p[0][0]+2·p[1][0]+p[2][0]), computed in ≥11-bit signed arithmetic without overflow.
REQ-017 Gy SHALL be (p[2][0]+2·p[2][1]+p[2][2]) − (p[0][0]+2·p[0][1]+p[0][2]), same width rule.
REQ-018 gx/gy SHALL be the absolute value, saturated to 255 when >255.
REQ-019 Latency: out_valid, gx and gy SHALL be registered, asserted on the rising edge following the edge that accepted the window-completing pixel.
REQ-020 Each frame SHALL yield exactly (IMG_W-2)·(IMG_H-2) out_valid pulses, in raster order of centers.
REQ-021 gx/gy SHALL hold their last value while out_valid is low.
REQ-022 Idle cycles (pixel_valid low) anywhere, including mid-row and across row/frame boundaries, SHALL not change counters, buffers or output values; only timing shifts.
REQ-023 Windows SHALL never mix pixels across a row wrap: first valid window of each row uses columns 0..2 of that row's three rows.
REQ-024 frame_done SHALL pulse with the out_valid for center (IMG_H-2, IMG_W-2) and at no other time.

Reset
REQ-025 While n_rst is low: row=0, col=0, out_valid=0, frame_done=0, gx=0, gy=0, window registers=0.
REQ-026 Line buffer contents need not be reset; they SHALL not affect any output before being rewritten in the new frame.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; the first accepted pixel after release is pixel (0,0).

Verification
REQ-028 Flat frame, all pixels 100, 16×16, continuous valid -> 196 out_valid pulses, all gx=0, gy=0, one frame_done with the 196th.
REQ-029 Vertical edge: cols 0-7 = 0, cols 8-15 = 50 -> centers at col 7 and 8: gx=200, gy=0; all other centers gx=0, gy=0.
REQ-030 Saturation: cols 0-7 = 0, cols 8-15 = 255 -> edge centers gx=255 (raw 1020), gy=0; horizontal edge rows 0-7 = 0, rows 8-15 = 50 -> centers at rows 7 and 8: gy=200, gx=0.
REQ-031 Random pixel_valid gaps (~50% duty) on the vertical-edge frame -> same 196 gx/gy values in same order as REQ-029; out_valid one cycle after each completing pixel.
REQ-032 n_rst pulsed low during row 5 -> outputs zero immediately; then a full flat frame of 100 -> exactly 196 pulses, all zero, frame_done once.
REQ-033 Two back-to-back frames without idle -> 392 pulses, frame_done twice; second frame's first out_valid follows its pixel (2,2).
